// File: rtl/anita4_trig_pkg.sv
// Shared definitions for the single-pol trigger test-pulse generator and its receiver bench.
package anita4_trig_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HIGH   = 2'd1,
    LOW    = 2'd2,
    FINISH = 2'd3
  } trig_state_t;

  localparam int MIN_LOW_DEFAULT = 2;

endpackage

// File: rtl/anita4_dcount.sv
// Loadable down-counter that parks at zero; times each phase of the pulse train.
module anita4_dcount #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/anita4_trig_pulse_gen.sv
// Burst generator of registered trigger pulses; the falling edge of TRIG_OUT is the event.
// START/STOP are single-cycle requests: START is accepted only in IDLE with STOP low; STOP always wins.
module anita4_trig_pulse_gen
  import anita4_trig_pkg::*;
#(
  parameter int HW      = 8,
  parameter int PW      = 16,
  parameter int NW      = 16,
  parameter int MIN_LOW = MIN_LOW_DEFAULT
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic          START,
  input  logic          STOP,
  input  logic [HW-1:0] HIGH_CYCLES,
  input  logic [PW-1:0] PERIOD,
  input  logic [NW-1:0] NPULSE,
  output logic          TRIG_OUT,
  output logic          BUSY,
  output logic          DONE,
  output logic [NW-1:0] SENT_COUNT,
  output logic [1:0]    STATE_DBG
);

  trig_state_t   state_q, state_d;
  logic          trig_q;
  logic [NW-1:0] sent_q;
  logic [HW-1:0] h_q;
  logic [PW-1:0] p_q;
  logic [NW-1:0] n_q;
  logic          stop_pend_q, stop_pend_d;

  logic          capture, sent_inc, last_pulse;
  logic          tmr_load, tmr_zero;
  logic [PW-1:0] tmr_val;

  // Clamp live config: at least one high cycle, and a period leaving MIN_LOW low cycles.
  logic [HW-1:0] h_in;
  logic [PW:0]   p_min;
  logic [PW-1:0] p_in;
  assign h_in  = (HIGH_CYCLES == '0) ? HW'(1) : HIGH_CYCLES;
  assign p_min = (PW+1)'(h_in) + (PW+1)'(MIN_LOW);
  assign p_in  = ({1'b0, PERIOD} >= p_min) ? PERIOD : p_min[PW-1:0];

  assign last_pulse = (n_q != '0) && ((sent_q + NW'(1)) == n_q);

  anita4_dcount #(.W(PW)) u_phase_tmr (
    .CLK      (CLK),
    .CLR_N    (CLR_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    capture     = 1'b0;
    sent_inc    = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          capture     = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = HIGH;
          tmr_load    = 1'b1;
          tmr_val     = PW'(h_in) - PW'(1);
        end
      end
      HIGH: begin
        // A high period is never truncated; STOP only decides where it goes next.
        if (tmr_zero) begin
          sent_inc = 1'b1;
          if (STOP || stop_pend_q || last_pulse) begin
            state_d = FINISH;
          end else begin
            state_d  = LOW;
            tmr_load = 1'b1;
            tmr_val  = p_q - PW'(h_q) - PW'(1);
          end
        end else if (STOP) begin
          stop_pend_d = 1'b1;
        end
      end
      LOW: begin
        if (STOP) begin
          state_d = FINISH;
        end else if (tmr_zero) begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = PW'(h_q) - PW'(1);
        end
      end
      FINISH: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      sent_q      <= '0;
      h_q         <= '0;
      p_q         <= '0;
      n_q         <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      // Registered from next-state so the downstream latch sees a glitch-free flop.
      trig_q      <= (state_d == HIGH);
      if (capture) begin
        h_q    <= h_in;
        p_q    <= p_in;
        n_q    <= NPULSE;
        sent_q <= '0;
      end else if (sent_inc) begin
        sent_q <= sent_q + NW'(1);
      end
    end
  end

  assign TRIG_OUT   = trig_q;
  assign BUSY       = (state_q == HIGH) || (state_q == LOW);
  assign DONE       = (state_q == FINISH);
  assign SENT_COUNT = sent_q;
  assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_anita4_trig_pulse_gen.sv
// Directed bench for the trigger test-pulse generator: burst table plus reset/abort sequences.
module tb_anita4_trig_pulse_gen;
  import anita4_trig_pkg::*;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic        stop;
  logic [7:0]  high_cycles;
  logic [15:0] period;
  logic [15:0] npulse;
  logic        trig_out;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;
  logic [1:0]  state_dbg;

  int n_cmp;
  int n_err;

  typedef struct {
    int high;
    int period;
    int npulse;
    int stop_at;
    int start_at;
    int exp_h;
    int exp_p;
    int exp_n;
    int exp_done;
  } vec_t;

  vec_t vecs[12];

  anita4_trig_pulse_gen dut (
    .CLK         (clk),
    .CLR_N       (clr_n),
    .START       (start),
    .STOP        (stop),
    .HIGH_CYCLES (high_cycles),
    .PERIOD      (period),
    .NPULSE      (npulse),
    .TRIG_OUT    (trig_out),
    .BUSY        (busy),
    .DONE        (done),
    .SENT_COUNT  (sent_count),
    .STATE_DBG   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sample at each negedge; idx 0 is the cycle right after the edge that accepts START.
  task automatic run_burst(input string tag, input vec_t v);
    int rise_q[$];
    int fall_q[$];
    int prev, done_idx, busy_err, sent_err, sent_done, w_err, p_err, post_err;
    high_cycles = 8'(v.high);
    period      = 16'(v.period);
    npulse      = 16'(v.npulse);
    start       = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    prev     = 0;
    done_idx = -1;
    busy_err = 0;
    sent_err = 0;
    sent_done = -1;
    for (int i = 0; i < 2000 && done_idx < 0; i++) begin
      if (trig_out && prev == 0) rise_q.push_back(i);
      if (!trig_out && prev == 1) fall_q.push_back(i);
      prev = int'(trig_out);
      if (int'(sent_count) != fall_q.size()) sent_err++;
      if (done) begin
        done_idx  = i;
        sent_done = int'(sent_count);
        if (busy) busy_err++;
      end else if (!busy) begin
        busy_err++;
      end
      if (i == v.stop_at) stop = 1'b1;
      if (i == v.start_at) begin
        start       = 1'b1;
        high_cycles = 8'd7;
        period      = 16'd20;
        npulse      = 16'd9;
      end
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
    end
    check({tag, "_done_idx"}, done_idx, v.exp_done);
    check({tag, "_n_rises"}, rise_q.size(), v.exp_n);
    check({tag, "_n_falls"}, fall_q.size(), v.exp_n);
    if (rise_q.size() > 0) check({tag, "_first_rise"}, rise_q[0], 0);
    w_err = 0;
    p_err = 0;
    for (int k = 0; k < rise_q.size() && k < fall_q.size(); k++)
      if (fall_q[k] - rise_q[k] != v.exp_h) w_err++;
    for (int k = 1; k < rise_q.size(); k++)
      if (rise_q[k] - rise_q[k-1] != v.exp_p) p_err++;
    check({tag, "_high_width_errs"}, w_err, 0);
    check({tag, "_period_errs"}, p_err, 0);
    check({tag, "_sent_at_done"}, sent_done, v.exp_n);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_sent_track_errs"}, sent_err, 0);
    post_err = 0;
    for (int k = 0; k < 6; k++) begin
      if (trig_out || busy || done) post_err++;
      if (int'(state_dbg) != int'(IDLE)) post_err++;
      if (int'(sent_count) != v.exp_n) post_err++;
      @(negedge clk);
    end
    check({tag, "_post_idle_errs"}, post_err, 0);
  endtask

  initial begin
    int idle_err;
    vec_t rv;
    n_cmp = 0;
    n_err = 0;
    clr_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    high_cycles = '0;
    period      = '0;
    npulse      = '0;

    //            high per  n  stop start  h  p  n  done
    vecs[0]  = '{3,  10,  4, -1, -1,  3, 10, 4, 33};
    vecs[1]  = '{0,  1,   2, -1, -1,  1, 3,  2, 4};
    vecs[2]  = '{5,  4,   3, -1, -1,  5, 7,  3, 19};
    vecs[3]  = '{1,  2,   1, -1, -1,  1, 3,  1, 1};
    vecs[4]  = '{8,  20,  2, -1, -1,  8, 20, 2, 28};
    vecs[5]  = '{2,  8,   5, -1, -1,  2, 8,  5, 34};
    vecs[6]  = '{2,  5,   0, 11, -1,  2, 5,  3, 12};
    vecs[7]  = '{3,  6,   0, 12, -1,  3, 6,  3, 15};
    vecs[8]  = '{2,  5,   0, 8,  -1,  2, 5,  2, 9};
    vecs[9]  = '{3,  10,  4, -1, 5,   3, 10, 4, 33};
    vecs[10] = '{3,  10,  4, -1, 33,  3, 10, 4, 33};
    vecs[11] = '{2,  5,   2, 5,  -1,  2, 5,  2, 7};

    repeat (3) @(negedge clk);
    check("rst_trig", int'(trig_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sent", int'(sent_count), 0);
    check("rst_state", int'(state_dbg), int'(IDLE));
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 12; v++) run_burst($sformatf("v%0d", v), vecs[v]);

    // START and STOP together in IDLE: STOP wins, nothing happens.
    high_cycles = 8'd2;
    period      = 16'd5;
    npulse      = 16'd1;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    idle_err = 0;
    for (int k = 0; k < 10; k++) begin
      if (trig_out || busy || done) idle_err++;
      @(negedge clk);
    end
    check("start_stop_idle_errs", idle_err, 0);

    // Asynchronous reset in the middle of the second pulse's high phase.
    high_cycles = 8'd8;
    period      = 16'd20;
    npulse      = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (21) @(negedge clk);
    check("midrst_pre_trig", int'(trig_out), 1);
    check("midrst_pre_sent", int'(sent_count), 1);
    #2 clr_n = 1'b0;
    #1;
    check("midrst_trig", int'(trig_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_sent", int'(sent_count), 0);
    @(negedge clk);
    clr_n = 1'b1;
    idle_err = 0;
    for (int k = 0; k < 10; k++) begin
      if (trig_out || busy || done) idle_err++;
      if (int'(state_dbg) != int'(IDLE)) idle_err++;
      @(negedge clk);
    end
    check("midrst_idle_errs", idle_err, 0);
    rv = '{2, 4, 1, -1, -1, 2, 4, 1, 2};
    run_burst("post_rst", rv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
